// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: ALU operation codes plus MIPS opcode
// and funct field values recognised by the decoder.
package id_ex_stage_pkg;

  typedef logic [3:0] aluc_t;

  localparam aluc_t ALU_ADD = 4'b0000;
  localparam aluc_t ALU_SUB = 4'b0100;
  localparam aluc_t ALU_AND = 4'b0001;
  localparam aluc_t ALU_OR  = 4'b0101;
  localparam aluc_t ALU_XOR = 4'b0010;
  localparam aluc_t ALU_LUI = 4'b0110;
  localparam aluc_t ALU_SLL = 4'b0011;
  localparam aluc_t ALU_SRL = 4'b0111;
  localparam aluc_t ALU_SRA = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;

endpackage

// File: rtl/id_ex_stage_decode.sv
// Combinational MIPS decoder: instruction plus forwarded operands in,
// ALU code, operands, destination and write/illegal flags out.
module id_ex_stage_decode
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       inst,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output aluc_t             aluc,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [4:0]        wn,
  output logic              wreg,
  output logic              illegal
);

  logic [5:0]  op, funct;
  logic [4:0]  rt, rd, shamt;
  logic [15:0] imm;
  logic [DATA_W-1:0] imm_sext, imm_zext, shamt_zext;
  logic unused_rs;

  assign op    = inst[31:26];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign shamt = inst[10:6];
  assign funct = inst[5:0];
  assign imm   = inst[15:0];

  // rs arrives already read and forwarded as rs_val; its field is not needed.
  assign unused_rs = ^inst[25:21];

  assign imm_sext   = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zext   = {{(DATA_W-16){1'b0}}, imm};
  assign shamt_zext = {{(DATA_W-5){1'b0}}, shamt};

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    aluc    = ALU_ADD;
    a       = rs_val;
    b       = rt_val;
    wn      = rt;
    wreg    = 1'b1;
    illegal = 1'b0;

    case (op)
      OP_RTYPE: begin
        wn = rd;
        case (funct)
          FN_ADD, FN_ADDU: aluc = ALU_ADD;
          FN_SUB, FN_SUBU: aluc = ALU_SUB;
          FN_AND:          aluc = ALU_AND;
          FN_OR:           aluc = ALU_OR;
          FN_XOR:          aluc = ALU_XOR;
          FN_SLL: begin aluc = ALU_SLL; a = shamt_zext; end
          FN_SRL: begin aluc = ALU_SRL; a = shamt_zext; end
          FN_SRA: begin aluc = ALU_SRA; a = shamt_zext; end
          default:         illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: b = imm_sext;
      OP_ANDI: begin aluc = ALU_AND; b = imm_zext; end
      OP_ORI:  begin aluc = ALU_OR;  b = imm_zext; end
      OP_XORI: begin aluc = ALU_XOR; b = imm_zext; end
      OP_LUI:  begin aluc = ALU_LUI; a = '0; b = imm_zext; end
      OP_LW:   b = imm_sext;
      OP_SW:   begin b = imm_sext; wreg = 1'b0; end
      default: illegal = 1'b1;
    endcase

    // An illegal word travels as an inert ADD of zeros with no writeback.
    if (illegal) begin
      aluc = ALU_ADD;
      a    = '0;
      b    = '0;
      wn   = '0;
      wreg = 1'b0;
    end

    if (wn == 5'd0) wreg = 1'b0;
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage plus ID/EX pipeline register with the hazard-unit stall/flush
// handshake; flush beats stall, stall beats a fresh load.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic [31:0]       id_inst,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic              stall,
  input  logic              flush,
  output logic              id_ready,
  output logic              ex_valid,
  output aluc_t             ex_aluc,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [4:0]        ex_wn,
  output logic              ex_wreg,
  output logic              ex_illegal
);

  aluc_t             dec_aluc;
  logic [DATA_W-1:0] dec_a, dec_b;
  logic [4:0]        dec_wn;
  logic              dec_wreg, dec_illegal;
  logic              bubble;

  id_ex_stage_decode #(.DATA_W(DATA_W)) u_decode (
    .inst    (id_inst),
    .rs_val  (id_rs_val),
    .rt_val  (id_rt_val),
    .aluc    (dec_aluc),
    .a       (dec_a),
    .b       (dec_b),
    .wn      (dec_wn),
    .wreg    (dec_wreg),
    .illegal (dec_illegal)
  );

  assign id_ready = ~stall | flush;

  // Without trapping, an unknown word simply never enters EX.
  assign bubble = flush | ~id_valid | (dec_illegal & ~ILLEGAL_TRAP);

  // NOTE: state registers use non-blocking assignments so all fields update together at the edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ex_valid   <= 1'b0;
      ex_aluc    <= ALU_ADD;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_wn      <= '0;
      ex_wreg    <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (bubble && (flush || !stall)) begin
      ex_valid   <= 1'b0;
      ex_aluc    <= ALU_ADD;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_wn      <= '0;
      ex_wreg    <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (!stall) begin
      ex_valid   <= 1'b1;
      ex_aluc    <= dec_aluc;
      ex_a       <= dec_a;
      ex_b       <= dec_b;
      ex_wn      <= dec_wn;
      ex_wreg    <= dec_wreg;
      ex_illegal <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode vectors, stall/flush handshake,
// illegal trapping in both ILLEGAL_TRAP modes and asynchronous reset.
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        resetn;
  logic        id_valid;
  logic [31:0] id_inst, id_rs_val, id_rt_val;
  logic        stall, flush;

  logic        id_ready, ex_valid, ex_wreg, ex_illegal;
  logic [3:0]  ex_aluc;
  logic [31:0] ex_a, ex_b;
  logic [4:0]  ex_wn;

  logic        nt_ready, nt_valid, nt_wreg, nt_illegal;
  logic [3:0]  nt_aluc;
  logic [31:0] nt_a, nt_b;
  logic [4:0]  nt_wn;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clock = ~clock;

  id_ex_stage #(.DATA_W(32), .ILLEGAL_TRAP(1'b1)) dut (
    .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_inst(id_inst),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .stall(stall), .flush(flush),
    .id_ready(id_ready), .ex_valid(ex_valid), .ex_aluc(ex_aluc), .ex_a(ex_a),
    .ex_b(ex_b), .ex_wn(ex_wn), .ex_wreg(ex_wreg), .ex_illegal(ex_illegal)
  );

  id_ex_stage #(.DATA_W(32), .ILLEGAL_TRAP(1'b0)) dut_notrap (
    .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_inst(id_inst),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .stall(stall), .flush(flush),
    .id_ready(nt_ready), .ex_valid(nt_valid), .ex_aluc(nt_aluc), .ex_a(nt_a),
    .ex_b(nt_b), .ex_wn(nt_wn), .ex_wreg(nt_wreg), .ex_illegal(nt_illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_ex(input string tag, input logic v, input logic [3:0] aluc,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wn, input logic wreg, input logic ill);
    check({tag, ".valid"},   ex_valid,   v);
    check({tag, ".aluc"},    ex_aluc,    aluc);
    check({tag, ".a"},       ex_a,       a);
    check({tag, ".b"},       ex_b,       b);
    check({tag, ".wn"},      ex_wn,      wn);
    check({tag, ".wreg"},    ex_wreg,    wreg);
    check({tag, ".illegal"}, ex_illegal, ill);
  endtask

  // Present inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] rs,
                      input logic [31:0] rt, input logic st, input logic fl);
    id_valid  = v;
    id_inst   = inst;
    id_rs_val = rs;
    id_rt_val = rt;
    stall     = st;
    flush     = fl;
    @(posedge clock);
    #1;
  endtask

  localparam logic [31:0] I_ADD  = 32'h0022_1820; // add  r3, r1, r2
  localparam logic [31:0] I_SRA  = 32'h0004_1103; // sra  r2, r4, 4
  localparam logic [31:0] I_ADDI = 32'h2022_FFFF; // addi r2, r1, -1
  localparam logic [31:0] I_ORI  = 32'h3422_FFFF; // ori  r2, r1, 0xffff
  localparam logic [31:0] I_LUI  = 32'h3C02_1234; // lui  r2, 0x1234
  localparam logic [31:0] I_SW   = 32'hAC22_0004; // sw   r2, 4(r1)
  localparam logic [31:0] I_LW   = 32'h8C25_FFF8; // lw   r5, -8(r1)
  localparam logic [31:0] I_BAD  = 32'hFC00_0000; // op 111111
  localparam logic [31:0] I_SLT  = 32'h0022_182A; // slt: funct not supported
  localparam logic [31:0] I_ADD0 = 32'h0022_0020; // add r0, r1, r2

  initial begin
    resetn = 1'b0;
    id_valid = 1'b0; id_inst = '0; id_rs_val = '0; id_rt_val = '0;
    stall = 1'b0; flush = 1'b0;
    #12;
    check_ex("reset", 0, 4'b0000, 0, 0, 0, 0, 0);
    check("reset.id_ready", id_ready, 1'b1);
    resetn = 1'b1;

    step(0, I_ADD, 32'd1, 32'd2, 0, 0);
    check_ex("idle", 0, 4'b0000, 0, 0, 0, 0, 0);

    step(1, I_SRA, 32'h0, 32'hF000_0000, 0, 0);
    check_ex("sra", 1, 4'b1111, 32'd4, 32'hF000_0000, 5'd2, 1, 0);

    step(1, I_ADDI, 32'd5, 32'h0, 0, 0);
    check_ex("addi", 1, 4'b0000, 32'd5, 32'hFFFF_FFFF, 5'd2, 1, 0);

    step(1, I_ORI, 32'h1111_0000, 32'h0, 0, 0);
    check_ex("ori", 1, 4'b0101, 32'h1111_0000, 32'h0000_FFFF, 5'd2, 1, 0);

    step(1, I_LUI, 32'hDEAD_BEEF, 32'h0, 0, 0);
    check_ex("lui", 1, 4'b0110, 32'h0, 32'h0000_1234, 5'd2, 1, 0);

    step(1, I_SW, 32'h100, 32'h55, 0, 0);
    check_ex("sw", 1, 4'b0000, 32'h100, 32'h4, 5'd2, 0, 0);

    step(1, I_LW, 32'h200, 32'h0, 0, 0);
    check_ex("lw", 1, 4'b0000, 32'h200, 32'hFFFF_FFF8, 5'd5, 1, 0);

    step(1, I_ADD0, 32'd7, 32'd9, 0, 0);
    check_ex("add_r0", 1, 4'b0000, 32'd7, 32'd9, 5'd0, 0, 0);

    // Stall holds the add for three cycles while new words are offered.
    step(1, I_ADD, 32'd10, 32'd20, 0, 0);
    check_ex("add", 1, 4'b0000, 32'd10, 32'd20, 5'd3, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, I_SRA, 32'h0, 32'h1234, 1, 0);
      check_ex($sformatf("stall%0d", i), 1, 4'b0000, 32'd10, 32'd20, 5'd3, 1, 0);
      check($sformatf("stall%0d.id_ready", i), id_ready, 1'b0);
    end
    id_valid = 1'b1; id_inst = I_SRA; stall = 1'b1; flush = 1'b1;
    #1;
    check("stall_flush.id_ready", id_ready, 1'b1);
    step(1, I_SRA, 32'h0, 32'h1234, 1, 1);
    check_ex("stall_flush", 0, 4'b0000, 0, 0, 0, 0, 0);

    // Illegal opcode: trapped in one instance, dropped in the other.
    step(1, I_BAD, 32'hAAAA, 32'hBBBB, 0, 0);
    check_ex("illegal_op", 1, 4'b0000, 0, 0, 0, 0, 1);
    check("illegal_op.notrap_valid", nt_valid, 1'b0);
    check("illegal_op.notrap_illegal", nt_illegal, 1'b0);

    step(1, I_ADD, 32'd1, 32'd2, 1, 0);
    check_ex("illegal_hold", 1, 4'b0000, 0, 0, 0, 0, 1);

    step(1, 32'h0000_0000, 32'd3, 32'd4, 0, 0);
    check_ex("nop", 1, 4'b0011, 32'd0, 32'd4, 5'd0, 0, 0);
    check("nop.notrap_valid", nt_valid, 1'b1);

    step(1, I_SLT, 32'd1, 32'd2, 0, 0);
    check_ex("illegal_funct", 1, 4'b0000, 0, 0, 0, 0, 1);
    check("illegal_funct.notrap_valid", nt_valid, 1'b0);

    step(1, I_BAD, 32'd1, 32'd2, 0, 1);
    check_ex("flush_illegal", 0, 4'b0000, 0, 0, 0, 0, 0);

    // Reset arriving mid-stall clears EX without waiting for an edge.
    step(1, I_ADD, 32'd10, 32'd20, 0, 0);
    check_ex("pre_reset", 1, 4'b0000, 32'd10, 32'd20, 5'd3, 1, 0);
    stall = 1'b1;
    #3;
    resetn = 1'b0;
    #1;
    check_ex("async_reset", 0, 4'b0000, 0, 0, 0, 0, 0);
    check("async_reset.notrap_valid", nt_valid, 1'b0);
    @(posedge clock);
    #2;
    resetn = 1'b1;
    step(1, I_ADD, 32'd10, 32'd20, 1, 0);
    check_ex("post_reset_stall", 0, 4'b0000, 0, 0, 0, 0, 0);
    step(0, I_ADD, 32'd10, 32'd20, 0, 0);
    check_ex("post_reset_idle", 0, 4'b0000, 0, 0, 0, 0, 0);
    step(1, I_ADD, 32'd10, 32'd20, 0, 0);
    check_ex("post_reset_add", 1, 4'b0000, 32'd10, 32'd20, 5'd3, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register; it is the producer side of the ALU control interface.
- Decodes a 32-bit MIPS instruction into the 4-bit ALU operation code and the two ALU operands, and registers them for the EX stage.
- Handles the stall/flush handshake with the hazard unit. Operand values arrive already forwarded from the register-file/forwarding logic.

Parameters:
- DATA_W, 32, operand width (only 32 is supported).
- ILLEGAL_TRAP, 1, 1 = flag unknown opcodes on ex_illegal; 0 = silently convert them to bubbles.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- id_valid  in  1  instruction in ID is valid.
- id_inst  in  32  instruction word.
- id_rs_val  in  32  forwarded rs value.
- id_rt_val  in  32  forwarded rt value.
- stall  in  1  hold EX register; ID must not advance.
- flush  in  1  load a bubble into EX.
- id_ready  out  1  ID may advance; equals ~stall | flush.
- ex_valid  out  1  EX register holds a live instruction.
- ex_aluc  out  4  ALU operation code.
- ex_a  out  32  ALU operand a.
- ex_b  out  32  ALU operand b.
- ex_wn  out  5  destination register number.
- ex_wreg  out  1  register write enable.
- ex_illegal  out  1  unknown opcode/funct was decoded.

Behaviour:
- Reset: resetn is asynchronous, active-low, one clock domain. On reset every ex_* output is 0. id_ready follows its equation combinationally.
- Latency: one cycle, ID to EX.
- Register update priority on each clock edge:
  - flush = 1 -> bubble (all ex_* = 0). Flush wins over stall.
  - else stall = 1 -> hold all ex_* unchanged.
  - else id_valid = 0 -> bubble.
  - else load the decoded fields.
- R-type (op = 000000), by funct:
  - 100000/100001 -> aluc 0000 (ADD).
  - 100010/100011 -> 0100 (SUB).
  - 100100 -> 0001 (AND); 100101 -> 0101 (OR); 100110 -> 0010 (XOR).
  - 000000 -> 0011 (SLL); 000010 -> 0111 (SRL); 000011 -> 1111 (SRA).
  - Shifts: a = {27'b0, shamt[10:6]}, b = rt_val. All other R-type: a = rs_val, b = rt_val.
  - wn = rd.
- I-type: wn = rt; a = rs_val.
  - addi 001000 / addiu 001001 -> 0000, b = sign-extended imm.
  - andi 001100 -> 0001, b = zero-extended imm.
  - ori 001101 -> 0101, zero-extended.
  - xori 001110 -> 0010, zero-extended.
  - lui 001111 -> 0110, b = zero-extended imm, a = 0.
  - lw 100011 -> 0000, sign-extended, wreg = 1.
  - sw 101011 -> 0000, sign-extended, wreg = 0.
- wreg is forced to 0 when wn = 0. The all-zero word (nop = sll r0) therefore loads valid = 1, wreg = 0.
- Unknown op/funct:
  - ILLEGAL_TRAP = 1 -> valid = 1, illegal = 1, wreg = 0, aluc = 0000, a = b = 0.
  - ILLEGAL_TRAP = 0 -> bubble.
- ex_illegal is held during stall and cleared by flush or any subsequent load.
- Reset asserted mid-stall clears the register immediately. The first edge after release behaves per the priority list above.

Decomposition:
- Shared package holds:
  - ALU code constants: ALU_ADD 0000, ALU_SUB 0100, ALU_AND 0001, ALU_OR 0101, ALU_XOR 0010, ALU_LUI 0110, ALU_SLL 0011, ALU_SRL 0111, ALU_SRA 1111.
  - Opcode and funct constants.
- One sub-module is natural: id_decode (purely combinational, instruction plus operands -> aluc/a/b/wn/wreg/illegal). id_ex_stage adds the register and the handshake.

Test Plan:
- Reset / bubble: assert resetn = 0 mid-stream -> all ex_* = 0 immediately. With id_valid = 0 after release -> ex_valid stays 0.
- SRA decode: inst = 0x00041103 (sra r2, r4, 4), rt_val = 0xF0000000, valid -> next cycle ex_aluc = 1111, ex_a = 4, ex_b = 0xF0000000, ex_wn = 2, ex_wreg = 1.
- addi sign-extend: inst = 0x2022FFFF (addi r2, r1, -1), rs_val = 5 -> ex_aluc = 0000, ex_a = 5, ex_b = 0xFFFFFFFF, ex_wn = 2.
- Zero-extend and lui: ori inst 0x3422FFFF -> ex_b = 0x0000FFFF, ex_aluc = 0101. lui inst 0x3C021234 -> ex_aluc = 0110, ex_a = 0, ex_b = 0x00001234.
- Stall then flush: load add, then stall = 1 for 3 cycles with new instructions presented -> EX holds add and id_ready = 0. Then stall = flush = 1 together -> bubble loaded, id_ready = 1.
- Illegal and r0: op 111111 with ILLEGAL_TRAP = 1 -> ex_illegal = 1, ex_wreg = 0. inst = 0x00000000 -> ex_valid = 1, ex_wreg = 0.
